// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus arbiter.
// Holds the RESULT bundle and the widths it is built from.
package cdb_arbiter_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_TAG_W = 6;

  typedef struct packed {
    logic [XLEN-1:0]      value;
    logic [ROB_TAG_W-1:0] ROB_tag;
  } RESULT;

  // Pointer that follows grant index g in a ring of n entries.
  function automatic int unsigned rr_next(
    input int unsigned g,
    input int unsigned n
  );
    return (g == n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: one-hot grant of the first request at or after ptr.
// Ports: req[N] requests, ptr start index, gnt one-hot grant, any = |req.
module rr_picker #(
  parameter  int N  = 5,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   sel;
  logic [2*N-1:0] back;
  logic           found;

  // Rotate req so ptr sits at bit 0, pick the lowest set bit,
  // then rotate the one-hot back by folding the upper half down.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rot[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
    back = {{N{1'b0}}, sel} << ptr;
    gnt  = back[N-1:0] | back[2*N-1:N];
  end

  assign any = |req;

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one result slot per FU, round-robin grant of one slot per cycle.
// Ports: clock/reset/squash, fu_valid/fu_results/fu_ready, held_results, select_flag/select_signal, pending_count.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int FU_NUM = 5,
  localparam int PW     = $clog2(FU_NUM),
  localparam int CW     = $clog2(FU_NUM+1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 squash,
  input  logic [FU_NUM-1:0]    fu_valid,
  input  RESULT [FU_NUM-1:0]   fu_results,
  output logic [FU_NUM-1:0]    fu_ready,
  output RESULT [FU_NUM-1:0]   held_results,
  output logic                 select_flag,
  output logic [FU_NUM-1:0]    select_signal,
  output logic [CW-1:0]        pending_count
);

  logic [FU_NUM-1:0]  slot_valid_q, slot_valid_d;
  RESULT [FU_NUM-1:0] slot_res_q, slot_res_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [FU_NUM-1:0]  gnt;
  logic               any;
  logic [PW-1:0]      gnt_idx;

  rr_picker #(.N(FU_NUM)) u_pick (
    .req (slot_valid_q),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .any (any)
  );

  assign select_signal = gnt;
  assign select_flag   = any;
  assign held_results  = slot_res_q;
  // A granted slot empties on this edge, so it can take a new result.
  assign fu_ready      = ~slot_valid_q | gnt;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      if (gnt[i]) gnt_idx = PW'(i);
    end
  end

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_res_d   = slot_res_q;
    rr_ptr_d     = rr_ptr_q;
    if (squash) begin
      slot_valid_d = '0;
    end else begin
      for (int i = 0; i < FU_NUM; i++) begin
        // Refill wins over drain on the same slot.
        if (fu_valid[i] && fu_ready[i]) begin
          slot_valid_d[i] = 1'b1;
          slot_res_d[i]   = fu_results[i];
        end else if (gnt[i]) begin
          slot_valid_d[i] = 1'b0;
        end
      end
      if (any) begin
        rr_ptr_d = PW'(rr_next(32'(gnt_idx), FU_NUM));
      end
    end
  end

  always_comb begin
    pending_count = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      pending_count = pending_count + CW'(slot_valid_q[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid_q <= '0;
      slot_res_q   <= '0;
      rr_ptr_q     <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_res_q   <= slot_res_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic
// checked against a slot/queue reference model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = 5;

  logic           clock = 1'b0;
  logic           reset;
  logic           squash;
  logic [N-1:0]   fu_valid;
  RESULT [N-1:0]  fu_results;
  logic [N-1:0]   fu_ready;
  RESULT [N-1:0]  held_results;
  logic           select_flag;
  logic [N-1:0]   select_signal;
  logic [2:0]     pending_count;

  always #5 clock = ~clock;

  cdb_arbiter #(.FU_NUM(N)) dut (
    .clock         (clock),
    .reset         (reset),
    .squash        (squash),
    .fu_valid      (fu_valid),
    .fu_results    (fu_results),
    .fu_ready      (fu_ready),
    .held_results  (held_results),
    .select_flag   (select_flag),
    .select_signal (select_signal),
    .pending_count (pending_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  bit    mv[N];
  RESULT mres[N];
  int    mptr;
  bit    macc[N];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int mgrant();
    int g = -1;
    for (int k = 0; k < N; k++) begin
      int j = (mptr + k) % N;
      if (mv[j] && g < 0) g = j;
    end
    return g;
  endfunction

  task automatic check_outs(string tag);
    int g = mgrant();
    logic [N-1:0] es = '0;
    logic [N-1:0] er;
    int pc = 0;
    if (g >= 0) es[g] = 1'b1;
    for (int i = 0; i < N; i++) begin
      er[i] = !mv[i] || (g == i);
      pc += int'(mv[i]);
    end
    chk($sformatf("%s.sig", tag), 64'(select_signal), 64'(es));
    chk($sformatf("%s.flag", tag), 64'(select_flag), 64'(g >= 0));
    chk($sformatf("%s.pend", tag), 64'(pending_count), 64'(pc));
    chk($sformatf("%s.rdy", tag), 64'(fu_ready), 64'(er));
    for (int i = 0; i < N; i++) begin
      if (mv[i]) chk($sformatf("%s.held%0d", tag, i),
                     64'(held_results[i]), 64'(mres[i]));
    end
  endtask

  task automatic model_update(logic [N-1:0] v, bit sq, bit rst);
    int g = mgrant();
    for (int i = 0; i < N; i++) macc[i] = 1'b0;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mv[i] = 1'b0;
        mres[i] = '0;
      end
      mptr = 0;
    end else if (sq) begin
      for (int i = 0; i < N; i++) mv[i] = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        macc[i] = v[i] && (!mv[i] || g == i);
        if (macc[i]) begin
          mv[i] = 1'b1;
          mres[i] = fu_results[i];
        end else if (g == i) begin
          mv[i] = 1'b0;
        end
      end
      if (g >= 0) mptr = (g + 1) % N;
    end
  endtask

  task automatic step(logic [N-1:0] v, bit sq, bit rst, bit do_chk);
    @(negedge clock);
    if (do_chk) check_outs("step");
    fu_valid = v;
    squash   = sq;
    reset    = rst;
    @(posedge clock);
    model_update(v, sq, rst);
    #1;
  endtask

  task automatic offer(int i, int tag);
    fu_results[i].value   = $urandom;
    fu_results[i].ROB_tag = ROB_TAG_W'(tag);
  endtask

  int tq_sent[$];
  int tq_got[$];
  logic [N-1:0] cur_v;
  int t;

  initial begin
    reset = 1'b1;
    squash = 1'b0;
    fu_valid = '1;
    for (int i = 0; i < N; i++) offer(i, i);

    // Reset with all FUs asserting valid.
    step('1, 0, 1, 0);
    step('1, 0, 1, 0);
    chk("rst.flag", 64'(select_flag), 64'(0));
    chk("rst.sig", 64'(select_signal), 64'(0));
    chk("rst.pend", 64'(pending_count), 64'(0));
    chk("rst.rdy", 64'(fu_ready), 64'(5'b11111));
    for (int i = 0; i < N; i++)
      chk($sformatf("rst.held%0d", i), 64'(held_results[i]), 64'(0));

    // Single FU.
    offer(2, 7);
    step(5'b00100, 0, 0, 1);
    chk("sf.sig", 64'(select_signal), 64'(5'b00100));
    chk("sf.tag", 64'(held_results[2].ROB_tag), 64'(7));
    step('0, 0, 0, 1);
    chk("sf.idle", 64'(select_flag), 64'(0));

    // Round-robin over a full load.
    step('0, 0, 1, 1);
    for (int i = 0; i < N; i++) offer(i, 10 + i);
    step('1, 0, 0, 1);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rr.gnt%0d", k), 64'(select_signal), 64'(1 << k));
      step('0, 0, 0, 1);
    end
    chk("rr.empty", 64'(select_flag), 64'(0));
    offer(3, 20);
    offer(0, 21);
    step(5'b01001, 0, 0, 1);
    chk("rr.wrap", 64'(select_signal), 64'(5'b00001));
    step('0, 0, 0, 1);
    step('0, 0, 0, 1);

    // Back-pressure on FU1 with FU0 pending.
    step('0, 0, 1, 1);
    t = 30;
    offer(0, 29);
    offer(1, t);
    for (int c = 0; c < 13; c++) begin
      logic [N-1:0] v;
      v = (c < 10) ? 5'b00010 : 5'b00000;
      if (c == 0) v[0] = 1'b1;
      step(v, 0, 0, 1);
      if (macc[1]) begin
        tq_sent.push_back(t);
        t++;
        offer(1, t);
      end
      if (select_signal[1]) tq_got.push_back(int'(held_results[1].ROB_tag));
    end
    chk("bp.count", 64'(tq_got.size()), 64'(tq_sent.size()));
    for (int i = 0; i < tq_sent.size() && i < tq_got.size(); i++)
      chk($sformatf("bp.tag%0d", i), 64'(tq_got[i]), 64'(tq_sent[i]));

    // Drain and refill of slot 3 on the same edge.
    step('0, 0, 1, 1);
    offer(3, 40);
    step(5'b01000, 0, 0, 1);
    offer(3, 41);
    step(5'b01000, 0, 0, 1);
    chk("dr.pend", 64'(pending_count), 64'(1));
    chk("dr.tag", 64'(held_results[3].ROB_tag), 64'(41));
    chk("dr.sig", 64'(select_signal), 64'(5'b01000));
    step('0, 0, 0, 1);

    // Squash with three pending and a new offer on FU4.
    step('0, 0, 1, 1);
    for (int i = 0; i < 3; i++) offer(i, 45 + i);
    step(5'b00111, 0, 0, 1);
    offer(4, 50);
    step(5'b10000, 1, 0, 1);
    chk("sq.pend", 64'(pending_count), 64'(0));
    chk("sq.flag", 64'(select_flag), 64'(0));
    chk("sq.rdy4", 64'(fu_ready[4]), 64'(1));

    // Random traffic; an FU keeps its offer until accepted.
    step('0, 0, 1, 1);
    cur_v = '0;
    for (int c = 0; c < 400; c++) begin
      bit sq;
      bit rst;
      for (int i = 0; i < N; i++) begin
        if (!(cur_v[i] && !macc[i])) begin
          cur_v[i] = 1'($urandom_range(0, 1));
          offer(i, int'($urandom_range(0, 63)));
        end
      end
      sq  = ($urandom % 32) == 0;
      rst = ($urandom % 100) == 0;
      step(cur_v, sq, rst, 1);
    end
    @(negedge clock);
    check_outs("end");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
